link_transmitter: RTL and testbench

Upstream end of a router-to-router link: the output-port transmitter that feeds a downstream input buffer under credit-based flow control. It tracks free downstream buffer slots with a credit counter, forwards flits from the switch only when a credit is available, and registers each flit onto the link for one cycle. A wormhole packet-framing FSM also drops flits that arrive out of packet order and flags them.

---
 rtl/noc_params.sv | 20 ++
 rtl/link_transmitter_credit_counter.sv | 47 ++++
 rtl/link_transmitter.sv | 95 +++++++++
 tb/tb_link_transmitter.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/noc_params.sv
// Shared NoC link parameters: flit width default, flit-type field and codes,
// and the packet-framing FSM state encoding.
// Imported by link_transmitter and its credit counter.
package noc_params;

  localparam int FLIT_SIZE_DEF = 16;

  // Flit type occupies the top TYPE_W bits of each flit.
  localparam int TYPE_W = 2;

  localparam logic [TYPE_W-1:0] HEAD     = 2'b00;
  localparam logic [TYPE_W-1:0] BODY     = 2'b01;
  localparam logic [TYPE_W-1:0] TAIL     = 2'b10;
  localparam logic [TYPE_W-1:0] HEADTAIL = 2'b11;

  // Wormhole framing FSM: PACKET means a HEAD has opened a packet that no TAIL has closed yet.
  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_PACKET = 1'b1;

endpackage

// File: rtl/link_transmitter_credit_counter.sv
// Purpose: up/down credit counter that saturates at MAX and flags overflow.
// Latency: count updates one cycle after inc/dec; overflow is combinational from inc/dec.
// Backpressure: none; dec must only be asserted while nonzero is high.
// Ports: clk, rst (sync, active-high), inc, dec -> count, nonzero, overflow.
module credit_counter #(
  parameter int MAX   = 8,
  parameter int WIDTH = $clog2(MAX + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  output logic [WIDTH-1:0] count,
  output logic             nonzero,
  output logic             overflow
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d  = count_q;
    overflow = 1'b0;
    if (inc && !dec) begin
      // A returned credit with the counter already full means the receiver
      // handed back more slots than exist; hold at MAX and report it.
      if (count_q == WIDTH'(MAX)) begin
        overflow = 1'b1;
      end else begin
        count_d = count_q + WIDTH'(1);
      end
    end else if (dec && !inc) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= WIDTH'(MAX);
    end else begin
      count_q <= count_d;
    end
  end

  assign count   = count_q;
  assign nonzero = (count_q != '0);

endmodule

// File: rtl/link_transmitter.sv
// Purpose: credit-based link transmitter with wormhole framing check; illegal flits are dropped and flagged.
// Latency: accepted flit appears on flit_o/valid_o one cycle later; credit_i visible on credits_o next cycle.
// Backpressure: ready_o = credits available (registered); the link itself has no backpressure.
// Ports: clk, rst | flit_i, valid_i, ready_o (switch side) | credit_i, flit_o, valid_o (link side)
//        | credits_o, busy_o (packet open), error_o (sticky: dropped flit or credit overflow).
module link_transmitter
  import noc_params::*;
#(
  parameter  int BUFFER_SIZE  = 8,
  parameter  int FLIT_SIZE    = FLIT_SIZE_DEF,
  localparam int CREDIT_WIDTH = $clog2(BUFFER_SIZE + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [FLIT_SIZE-1:0]    flit_i,
  input  logic                    valid_i,
  output logic                    ready_o,
  input  logic                    credit_i,
  output logic [FLIT_SIZE-1:0]    flit_o,
  output logic                    valid_o,
  output logic [CREDIT_WIDTH-1:0] credits_o,
  output logic                    busy_o,
  output logic                    error_o
);

  logic [0:0]           state_q, state_d;
  logic                 valid_q, valid_d;
  logic [FLIT_SIZE-1:0] flit_q, flit_d;
  logic                 error_q, error_d;

  logic [TYPE_W-1:0]    flit_type;
  logic                 accept, legal, send, drop;
  logic                 credits_nonzero, credit_overflow;

  credit_counter #(
    .MAX   (BUFFER_SIZE),
    .WIDTH (CREDIT_WIDTH)
  ) u_credit_counter (
    .clk      (clk),
    .rst      (rst),
    .inc      (credit_i),
    .dec      (send),
    .count    (credits_o),
    .nonzero  (credits_nonzero),
    .overflow (credit_overflow)
  );

  // ready_o comes straight from the registered credit count, so a credit
  // returned this cycle only opens the input on the next one.
  assign ready_o   = credits_nonzero;
  assign accept    = valid_i && ready_o;
  assign flit_type = flit_i[FLIT_SIZE-1 -: TYPE_W];

  // A packet may only open when none is open and only continue/close when one is.
  assign legal = (state_q == ST_IDLE) ? (flit_type == HEAD || flit_type == HEADTAIL)
                                      : (flit_type == BODY || flit_type == TAIL);
  assign send  = accept && legal;
  assign drop  = accept && !legal;

  always_comb begin
    state_d = state_q;
    valid_d = 1'b0;
    flit_d  = flit_q;
    if (send) begin
      valid_d = 1'b1;
      flit_d  = flit_i;
      if (state_q == ST_IDLE && flit_type == HEAD) begin
        state_d = ST_PACKET;
      end else if (state_q == ST_PACKET && flit_type == TAIL) begin
        state_d = ST_IDLE;
      end
    end
    error_d = error_q || drop || credit_overflow;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      valid_q <= 1'b0;
      flit_q  <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      flit_q  <= flit_d;
      error_q <= error_d;
    end
  end

  assign flit_o  = flit_q;
  assign valid_o = valid_q;
  assign busy_o  = (state_q == ST_PACKET);
  assign error_o = error_q;

endmodule

// File: tb/tb_link_transmitter.sv
module tb_link_transmitter;
  import noc_params::*;

  localparam int BUF = 8;
  localparam int FW  = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [FW-1:0] flit_i;
  logic          valid_i;
  logic          ready_o;
  logic          credit_i;
  logic [FW-1:0] flit_o;
  logic          valid_o;
  logic [3:0]    credits_o;
  logic          busy_o;
  logic          error_o;

  link_transmitter #(.BUFFER_SIZE(BUF), .FLIT_SIZE(FW)) dut (
    .clk       (clk),
    .rst       (rst),
    .flit_i    (flit_i),
    .valid_i   (valid_i),
    .ready_o   (ready_o),
    .credit_i  (credit_i),
    .flit_o    (flit_o),
    .valid_o   (valid_o),
    .credits_o (credits_o),
    .busy_o    (busy_o),
    .error_o   (error_o)
  );

  always #5 clk = ~clk;

  int ntests = 0;
  int nfail  = 0;

  // Reference model: abstract link state, not the RTL encoding.
  int            m_credits;
  bit            m_in_packet;
  bit            m_error;
  bit            m_valid;
  bit            mon_en = 1'b0;
  logic [FW-1:0] exp_q[$];

  task automatic chk(input string name, input int act, input int exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Apply one cycle of inputs, advance the model across the clock edge.
  task automatic drive(input bit r, input bit v, input logic [FW-1:0] f, input bit c);
    bit acc, ok, snd;
    logic [1:0] t;
    rst = r; valid_i = v; flit_i = f; credit_i = c;
    @(posedge clk);
    #1;
    t = f[FW-1:FW-2];
    if (r) begin
      m_credits = BUF; m_in_packet = 0; m_error = 0; m_valid = 0;
    end else begin
      acc = v && (m_credits > 0);
      ok  = m_in_packet ? (t == BODY || t == TAIL) : (t == HEAD || t == HEADTAIL);
      snd = acc && ok;
      if (acc && !ok) m_error = 1;
      m_valid = snd;
      if (snd) begin
        exp_q.push_back(f);
        if (t == HEAD) m_in_packet = 1;
        if (t == TAIL) m_in_packet = 0;
      end
      m_credits = m_credits + int'(c) - int'(snd);
      if (m_credits > BUF) begin
        m_credits = BUF;
        m_error   = 1;
      end
    end
    mon_en = 1'b1;
  endtask

  function automatic logic [FW-1:0] mk(input logic [1:0] t);
    logic [FW-3:0] payload;
    payload = (FW-2)'($urandom);
    return {t, payload};
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, '0, 0);
  endtask

  // Monitor: compares registered outputs against the model each cycle and
  // pops the scoreboard whenever the link presents a flit.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("valid_o", int'(valid_o), int'(m_valid));
      if (valid_o) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_flit", 1, 0);
        end else begin
          chk("flit_o", int'(flit_o), int'(exp_q.pop_front()));
        end
      end
      chk("credits_o", int'(credits_o), m_credits);
      chk("ready_o", int'(ready_o), int'(m_credits > 0));
      chk("busy_o", int'(busy_o), int'(m_in_packet));
      chk("error_o", int'(error_o), int'(m_error));
    end
  end

  initial begin
    rst = 1; valid_i = 0; flit_i = '0; credit_i = 0;

    // Reset values.
    drive(1, 0, '0, 0);
    chk("rst_credits", int'(credits_o), BUF);
    chk("rst_valid", int'(valid_o), 0);
    chk("rst_flit", int'(flit_o), 0);
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_error", int'(error_o), 0);

    // HEAD, BODY, TAIL back-to-back.
    drive(0, 1, mk(HEAD), 0);
    chk("hbt_busy_after_head", int'(busy_o), 1);
    chk("hbt_credits1", int'(credits_o), 7);
    drive(0, 1, mk(BODY), 0);
    chk("hbt_credits2", int'(credits_o), 6);
    drive(0, 1, mk(TAIL), 0);
    chk("hbt_credits3", int'(credits_o), 5);
    chk("hbt_busy_after_tail", int'(busy_o), 0);
    idle(1);

    // Credit exhaustion, then a single returned credit.
    drive(1, 0, '0, 0);
    for (int i = 0; i < BUF; i++) drive(0, 1, mk(HEADTAIL), 0);
    chk("exh_credits", int'(credits_o), 0);
    chk("exh_ready", int'(ready_o), 0);
    drive(0, 1, mk(HEADTAIL), 1);
    chk("exh_9th_not_sent", int'(valid_o), 0);
    chk("exh_ready_after_credit", int'(ready_o), 1);
    drive(0, 1, mk(HEADTAIL), 0);
    chk("exh_9th_sent", int'(valid_o), 1);
    chk("exh_credits_end", int'(credits_o), 0);

    // Simultaneous send and credit at credits = 3.
    drive(1, 0, '0, 0);
    for (int i = 0; i < 5; i++) drive(0, 1, mk(HEADTAIL), 0);
    chk("sim_credits_pre", int'(credits_o), 3);
    drive(0, 1, mk(HEADTAIL), 1);
    chk("sim_credits", int'(credits_o), 3);
    chk("sim_sent", int'(valid_o), 1);

    // Protocol violation: BODY while idle.
    drive(1, 0, '0, 0);
    drive(0, 1, mk(BODY), 0);
    chk("viol_no_valid", int'(valid_o), 0);
    chk("viol_credits", int'(credits_o), BUF);
    chk("viol_error", int'(error_o), 1);
    drive(0, 1, mk(HEAD), 0);
    chk("viol_head_sent", int'(valid_o), 1);
    chk("viol_error_sticky", int'(error_o), 1);

    // Credit overflow.
    drive(1, 0, '0, 0);
    drive(0, 0, '0, 1);
    chk("ovf_credits", int'(credits_o), BUF);
    chk("ovf_error", int'(error_o), 1);

    // Reset mid-packet.
    drive(1, 0, '0, 0);
    drive(0, 1, mk(HEAD), 0);
    drive(0, 1, mk(BODY), 0);
    chk("mid_credits", int'(credits_o), 6);
    drive(1, 1, mk(BODY), 0);
    chk("mid_rst_credits", int'(credits_o), BUF);
    chk("mid_rst_busy", int'(busy_o), 0);
    chk("mid_rst_valid", int'(valid_o), 0);
    chk("mid_rst_error", int'(error_o), 0);
    drive(0, 1, mk(BODY), 0);
    chk("mid_body_dropped", int'(valid_o), 0);
    chk("mid_body_error", int'(error_o), 1);

    // Randomised traffic, mostly framing-legal, with credit returns and rare resets.
    drive(1, 0, '0, 0);
    for (int i = 0; i < 600; i++) begin
      logic [1:0] t;
      bit r, v, c;
      if ($urandom_range(0, 3) != 0) begin
        t = m_in_packet ? (($urandom_range(0, 1) != 0) ? BODY : TAIL)
                        : (($urandom_range(0, 1) != 0) ? HEAD : HEADTAIL);
      end else begin
        t = 2'($urandom);
      end
      r = ($urandom_range(0, 99) == 0);
      v = ($urandom_range(0, 9) < 7);
      c = ($urandom_range(0, 9) < 5);
      drive(r, v, mk(t), c);
    end
    idle(3);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
